nts_api_master: RTL and testbench
=================================

Name: nts_api_master

Overview:
- Initiator for the 12-bit external NTS API bus: turns a valid/ready command stream into single-cycle cs/we/address/write_data transactions.
- Captures read data after a fixed latency and returns it on a valid/ready response stream.
- Sits between a host-side transport (UART/PCIe-lite command decoder, test sequencer) and the NTS API address-decode fan-out, which it drives as the sole bus master.

Parameters:
- READ_LATENCY, 1, cycles from the cs-asserted cycle to the read_data sample cycle; legal 0..15. At 0, data is sampled in the cs cycle.

Ports:
- i_clk  input  1  system clock, all logic rising-edge
- i_areset_n  input  1  asynchronous active-low reset
- i_cmd_valid  input  1  command present
- o_cmd_ready  output  1  command accepted when valid&&ready
- i_cmd_we  input  1  1=write, 0=read
- i_cmd_address  input  12  start API address
- i_cmd_write_data  input  32  write data (writes only)
- i_cmd_length  input  8  read burst length minus 1 (reads only, see Optional Feature)
- o_api_cs  output  1  API chip select, one-cycle pulse per word
- o_api_we  output  1  API write enable, valid with cs
- o_api_address  output  12  API address, valid with cs
- o_api_write_data  output  32  API write data, valid with cs
- i_api_read_data  input  32  API read data
- o_rsp_valid  output  1  read response present
- i_rsp_ready  input  1  response consumer ready
- o_rsp_read_data  output  32  captured read word
- o_rsp_address  output  12  address the word was read from
- o_rsp_last  output  1  final word of a burst
- o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, i_areset_n=0):
  - All outputs 0; state IDLE.
  - Latency counter, word counter and address register cleared.
  - Reset mid-transaction abandons it; no response is emitted.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - o_cmd_ready=1.
  - On valid&&ready, register we/address/write_data/length, then go to ISSUE.
  - o_cmd_ready=0 in every other state.
- ISSUE:
  - Exactly one cycle: o_api_cs=1, with we/address/write_data driven from registers.
  - Write: return to IDLE next cycle; no response generated.
  - Read with READ_LATENCY=0: sample i_api_read_data in this cycle and go to RESP.
  - Read with READ_LATENCY>0: load latency counter with READ_LATENCY-1 and go to WAIT.
- WAIT:
  - cs=0; decrement counter.
  - When the counter is 0, sample i_api_read_data into o_rsp_read_data, latch o_rsp_address, go to RESP.
- RESP:
  - o_rsp_valid=1; payload held stable until i_rsp_ready.
  - On handshake: if last, go to IDLE; else increment the address and go to ISSUE.
  - Backpressure is unbounded; the block waits indefinitely.
- Address arithmetic: 12-bit modulo; 0xFFF+1 wraps to 0x000, with no error.
- o_rsp_last: 1 when the word counter equals the registered length.
- Throughput:
  - Read word period is 2+READ_LATENCY cycles minimum (ISSUE, WAIT×L, RESP).
  - Writes are 2 cycles (IDLE accept, ISSUE).
- API outputs outside ISSUE: cs=0 and we=0. Address and write_data hold their last value; they are don't-care for the responder when cs=0.
- A command presented while busy is not accepted and must remain valid (standard valid/ready).

Optional Feature:
- Macro: NTS_API_MASTER_BURST_EN.
- Defined:
  - Reads issue i_cmd_length+1 words (1..256) at consecutive addresses, one response each.
  - o_rsp_last is set only on the final word.
- Undefined:
  - i_cmd_length is ignored; every read is a single word with o_rsp_last=1.
  - Word counter and length register are removed.
- Writes are always single-word in both builds.

Test Plan:
- Reset: hold i_areset_n=0 mid-READ (in WAIT) -> all outputs 0 immediately (asynchronously); after release, o_cmd_ready=1, no stray o_rsp_valid.
- Single write: cmd we=1, addr=0x012, data=0xDEADBEEF -> exactly one cycle cs=1,we=1,addr=0x012,data=0xDEADBEEF; no response; o_cmd_ready back to 1 two cycles after accept.
- Single read, READ_LATENCY=1: model returns 0xCAFE0001 one cycle after cs for addr 0x0A5 -> o_rsp_valid with data 0xCAFE0001, addr 0x0A5, last=1.
- Backpressure: i_rsp_ready=0 for 10 cycles during RESP -> payload stable, no further cs, o_cmd_ready=0; accept on ready.
- Burst with wrap (BURST_EN): read addr 0xFFE, length=3 -> cs at 0xFFE,0xFFF,0x000,0x001; four responses; last only on 0x001.
- READ_LATENCY=0 build: read addr 0x020 -> data sampled in cs cycle; response valid the next cycle.

Source files
------------

// File: rtl/nts_api_master_if.sv
// nts_api_master_if: command, API bus and response signals of the NTS API master.
interface nts_api_master_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_we;
  logic [11:0] i_cmd_address;
  logic [31:0] i_cmd_write_data;
  logic [7:0]  i_cmd_length;
  logic        o_api_cs;
  logic        o_api_we;
  logic [11:0] o_api_address;
  logic [31:0] o_api_write_data;
  logic [31:0] i_api_read_data;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_read_data;
  logic [11:0] o_rsp_address;
  logic        o_rsp_last;
  logic        o_busy;
  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_address, i_cmd_write_data, i_cmd_length,
    input  i_api_read_data, i_rsp_ready,
    output o_cmd_ready, o_api_cs, o_api_we, o_api_address, o_api_write_data,
    output o_rsp_valid, o_rsp_read_data, o_rsp_address, o_rsp_last, o_busy
  );
  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_address, i_cmd_write_data, i_cmd_length,
    output i_api_read_data, i_rsp_ready,
    input  o_cmd_ready, o_api_cs, o_api_we, o_api_address, o_api_write_data,
    input  o_rsp_valid, o_rsp_read_data, o_rsp_address, o_rsp_last, o_busy
  );
endinterface

// File: rtl/nts_api_master.sv
// nts_api_master: sole initiator of the 12-bit NTS API bus, command stream in, read responses out.
// Define NTS_API_MASTER_BURST_EN to enable multi-word read bursts (i_cmd_length+1 words).
module nts_api_master #(
  parameter int READ_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_areset_n,
  nts_api_master_if.master  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY == 0 ? 0 : READ_LATENCY - 1);
  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d, rsp_addr_q, rsp_addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  lat_q, lat_d;
  logic        last;
`ifdef NTS_API_MASTER_BURST_EN
  logic [7:0]  len_q, len_d, cnt_q, cnt_d;
  assign last = cnt_q == len_q;
`else
  assign last = 1'b1;
`endif
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rsp_addr_d = rsp_addr_q;
    lat_d      = lat_q;
`ifdef NTS_API_MASTER_BURST_EN
    len_d      = len_q;
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      IDLE: if (bus.i_cmd_valid) begin
        state_d = ISSUE;
        we_d    = bus.i_cmd_we;
        addr_d  = bus.i_cmd_address;
        wdata_d = bus.i_cmd_write_data;
`ifdef NTS_API_MASTER_BURST_EN
        len_d   = bus.i_cmd_length;
        cnt_d   = 8'd0;
`endif
      end
      ISSUE: if (we_q) state_d = IDLE;
        else if (READ_LATENCY == 0) begin
          rdata_d    = bus.i_api_read_data;
          rsp_addr_d = addr_q;
          state_d    = RESP;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = WAIT;
        end
      WAIT: if (lat_q == 4'd0) begin
          rdata_d    = bus.i_api_read_data;
          rsp_addr_d = addr_q;
          state_d    = RESP;
        end else lat_d = lat_q - 4'd1;
      RESP: if (bus.i_rsp_ready) begin
        state_d = last ? IDLE : ISSUE;
        addr_d  = last ? addr_q : addr_q + 12'd1;
`ifdef NTS_API_MASTER_BURST_EN
        cnt_d   = last ? cnt_q : cnt_q + 8'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rsp_addr_q <= '0;
      lat_q      <= '0;
`ifdef NTS_API_MASTER_BURST_EN
      len_q      <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rsp_addr_q <= rsp_addr_d;
      lat_q      <= lat_d;
`ifdef NTS_API_MASTER_BURST_EN
      len_q      <= len_d;
      cnt_q      <= cnt_d;
`endif
    end
  end
  // ready is gated by reset so every output reads 0 while reset is asserted
  assign bus.o_cmd_ready      = i_areset_n && state_q == IDLE;
  assign bus.o_api_cs         = state_q == ISSUE;
  assign bus.o_api_we         = state_q == ISSUE && we_q;
  assign bus.o_api_address    = addr_q;
  assign bus.o_api_write_data = wdata_q;
  assign bus.o_rsp_valid      = state_q == RESP;
  assign bus.o_rsp_read_data  = rdata_q;
  assign bus.o_rsp_address    = rsp_addr_q;
  assign bus.o_rsp_last       = state_q == RESP && last;
  assign bus.o_busy           = state_q != IDLE;
endmodule

// File: tb/tb_nts_api_master.sv
// tb_nts_api_master: table, hand-written and random command streams checked against a queue-based model.
module tb_nts_api_master;
  localparam int RL = 1;
  localparam int HI = RL == 0 ? 0 : RL - 1;
`ifdef NTS_API_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  typedef struct packed {logic we; logic [11:0] addr; logic [31:0] data;} bus_t;
  typedef struct packed {logic [11:0] addr; logic [31:0] data; logic last;} rsp_t;
  typedef struct {logic we; logic [11:0] addr; logic [31:0] wdata; logic [7:0] len; int exp_rsp;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  nts_api_master_if bus();
  nts_api_master #(.READ_LATENCY(RL)) dut (.i_clk(clk), .i_areset_n(rst_n), .bus(bus));
  logic [31:0] mem [4096];
  logic [11:0] hist [16];
  always @(posedge clk) begin
    hist[0] <= bus.o_api_address;
    for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
  end
  assign bus.i_api_read_data = RL == 0 ? mem[bus.o_api_address] : mem[hist[HI]];
  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  int errors = 0, checks = 0, cyc = 0, last_cs = 0, nrsp = 0, rmode = 0;
  always @(posedge clk) begin
    #1;
    bus.i_rsp_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ($urandom % 10 < 7) : 1'b0;
  end
  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic expect_cmd(logic we, logic [11:0] a, logic [31:0] d, logic [7:0] len);
    int n = BURST ? int'(len) + 1 : 1;
    if (we) exp_bus.push_back('{1'b1, a, d});
    else for (int i = 0; i < n; i++) begin
      exp_bus.push_back('{1'b0, a + 12'(i), 32'h0});
      exp_rsp.push_back('{a + 12'(i), mem[a + 12'(i)], i == n - 1});
    end
  endtask
  bus_t eb;
  rsp_t er, held;
  logic pv = 1'b0, prev_v = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pv = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (bus.o_api_cs) begin
        last_cs = cyc;
        check("cs_without_rsp_valid", bus.o_rsp_valid, 1'b0);
        if (exp_bus.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cs: got addr %h we %b expected no transaction", bus.o_api_address, bus.o_api_we);
        end else begin
          eb = exp_bus.pop_front();
          check("api_we", bus.o_api_we, eb.we);
          check("api_addr", bus.o_api_address, eb.addr);
          if (eb.we) check("api_wdata", bus.o_api_write_data, eb.data);
        end
      end
      if (bus.o_rsp_valid && !prev_v) check("rsp_latency", cyc - last_cs, RL + 1);
      if (pv) begin
        check("rsp_hold_valid", bus.o_rsp_valid, 1'b1);
        check("rsp_hold_payload", {bus.o_rsp_address, bus.o_rsp_read_data, bus.o_rsp_last}, held);
      end
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        nrsp++;
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got addr %h data %h expected no response", bus.o_rsp_address, bus.o_rsp_read_data);
        end else begin
          er = exp_rsp.pop_front();
          check("rsp_payload", {bus.o_rsp_address, bus.o_rsp_read_data, bus.o_rsp_last}, er);
        end
      end
      pv = bus.o_rsp_valid && !bus.i_rsp_ready;
      held = '{bus.o_rsp_address, bus.o_rsp_read_data, bus.o_rsp_last};
      prev_v = bus.o_rsp_valid;
    end
  end
  task automatic issue(logic we, logic [11:0] a, logic [31:0] d, logic [7:0] len);
    int k;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we = we;
    bus.i_cmd_address = a;
    bus.i_cmd_write_data = d;
    bus.i_cmd_length = len;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bus.o_cmd_ready) break;
    end
    checks++;
    if (k == 2000) begin
      errors++;
      $display("FAIL cmd_accept_timeout: got ready=0 for %0d cycles expected ready", k);
    end else expect_cmd(we, a, d, len);
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
  endtask
  task automatic drain();
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (!bus.o_busy && exp_bus.size() == 0 && exp_rsp.size() == 0) break;
    end
    checks++;
    if (k == 5000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bus %0d rsp pending expected 0", exp_bus.size(), exp_rsp.size());
    end
  endtask
  function automatic logic [127:0] all_outs();
    return {bus.o_cmd_ready, bus.o_api_cs, bus.o_api_we, bus.o_api_address, bus.o_api_write_data,
            bus.o_rsp_valid, bus.o_rsp_read_data, bus.o_rsp_address, bus.o_rsp_last, bus.o_busy};
  endfunction
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl[8];
    int n0, k;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_we = 1'b0;
    bus.i_cmd_address = '0;
    bus.i_cmd_write_data = '0;
    bus.i_cmd_length = '0;
    bus.i_rsp_ready = 1'b0;
    tbl[0] = '{1'b1, 12'h012, 32'hDEADBEEF, 8'd0, 0};
    tbl[1] = '{1'b0, 12'h000, 32'h0, 8'd0, 0};
    tbl[2] = '{1'b0, 12'hFFF, 32'h0, 8'd1, 0};
    tbl[3] = '{1'b1, 12'hFFF, 32'h12345678, 8'd5, 0};
    tbl[4] = '{1'b0, 12'h0A5, 32'h0, 8'd2, 0};
    tbl[5] = '{1'b1, 12'h000, 32'hFFFFFFFF, 8'd0, 0};
    tbl[6] = '{1'b0, 12'h7FF, 32'h0, 8'd7, 0};
    tbl[7] = '{1'b0, 12'hFFE, 32'h0, 8'd3, 0};
    for (int i = 0; i < 8; i++) tbl[i].exp_rsp = tbl[i].we ? 0 : (BURST ? int'(tbl[i].len) + 1 : 1);
    #2;
    check("reset_outputs", all_outs(), 128'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", bus.o_cmd_ready, 1'b1);
    check("post_reset_rsp_valid", bus.o_rsp_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n0 = nrsp;
      issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].len);
      drain();
      check("vec_rsp_count", nrsp - n0, tbl[i].exp_rsp);
    end
    issue(1'b1, 12'h012, 32'hDEADBEEF, 8'd0);
    @(negedge clk);
    check("wr_issue_bus", {bus.o_api_cs, bus.o_api_we, bus.o_api_address, bus.o_api_write_data}, {2'b11, 12'h012, 32'hDEADBEEF});
    check("wr_issue_ready", bus.o_cmd_ready, 1'b0);
    @(negedge clk);
    check("wr_done_idle", {bus.o_api_cs, bus.o_api_we, bus.o_cmd_ready, bus.o_rsp_valid}, 4'b0010);
    mem[12'h0A5] = 32'hCAFE0001;
    n0 = nrsp;
    issue(1'b0, 12'h0A5, 32'h0, 8'd0);
    drain();
    check("rd_single_count", nrsp - n0, 1);
    rmode = 2;
    issue(1'b0, 12'h0A5, 32'h0, 8'd0);
    for (k = 0; k < 100; k++) begin
      if (bus.o_rsp_valid) break;
      @(negedge clk);
    end
    check("bp_rsp_arrives", bus.o_rsp_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_stall", {bus.o_rsp_valid, bus.o_rsp_read_data, bus.o_rsp_address, bus.o_rsp_last, bus.o_api_cs, bus.o_cmd_ready},
            {1'b1, 32'hCAFE0001, 12'h0A5, 1'b1, 1'b0, 1'b0});
    end
    rmode = 0;
    drain();
`ifdef NTS_API_MASTER_BURST_EN
    n0 = nrsp;
    issue(1'b0, 12'hFFE, 32'h0, 8'd3);
    drain();
    check("burst_wrap_count", nrsp - n0, 4);
`endif
    issue(1'b0, 12'h123, 32'h0, 8'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 128'h0);
    exp_bus.delete();
    exp_rsp.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_ready", bus.o_cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_no_stray_rsp", bus.o_rsp_valid, 1'b0);
    end
    rmode = 1;
    for (int i = 0; i < 40; i++) begin
      issue($urandom % 3 == 0, 12'($urandom), $urandom, 8'($urandom % 4));
      if ($urandom % 4 == 0) drain();
    end
    drain();
    rmode = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
